data_tx_ser: RTL and testbench

Downstream consumer of the 8-bit processed/switched result word. It captures each result word on a strobe and buffers it in a small FIFO. Each buffered word is then transmitted as a framed serial stream on one pin: start bit, 8 data bits LSB first, even parity, stop bit. It decouples the one-word-per-strobe result path from a slower serial link and flags lost words.

---
 rtl/data_tx_pkg.sv | 27 ++
 rtl/data_tx_ser_fifo.sv | 82 ++++++++
 rtl/data_tx_ser.sv | 169 ++++++++++++++++
 tb/tb_data_tx_ser.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_tx_pkg.sv
// -----------------------------------------------------------------------------
// data_tx_pkg
// Shared definitions for the serial result-word transmitter:
//   - tx_state_e : framing FSM states
//   - START_BIT / STOP_BIT / IDLE_LVL : line levels of the serial frame
//   - cnt_w()    : width of a 0..depth occupancy counter
// -----------------------------------------------------------------------------
package data_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   // Occupancy counter must represent the value 'depth' itself, hence +1.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/data_tx_ser_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through output.
// Ports:
//   clk   : clock, rising edge
//   res   : asynchronous active-high reset (pointers and count only)
//   push  : write din this edge (ignored while full)
//   pop   : advance head this edge (ignored while empty)
//   din   : write data
//   dout  : head word, valid combinationally while !empty
//   full  : DEPTH words held
//   empty : no words held
//   cnt   : words currently held
// -----------------------------------------------------------------------------
module sync_fifo
   import data_tx_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_W-1:0]         din,
   output logic [DATA_W-1:0]         dout,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign cnt     = cnt_q;
   assign dout    = mem_q[rd_ptr_q];

   // Fullness/emptiness are judged on the pre-edge count, so a push into a
   // full FIFO is dropped even when a pop frees a slot on the same edge.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      cnt_d    = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries data only; no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/data_tx_ser.sv
// -----------------------------------------------------------------------------
// data_tx_ser
// Captures result words on a strobe into a small FIFO and transmits each as a
// serial frame: start bit, DATA_W data bits LSB first, even parity, stop bit,
// each held CLKS_PER_BIT clocks.
// Ports:
//   clk        : clock, rising edge
//   res        : asynchronous active-high reset (aborts frame, flushes FIFO)
//   data_in    : result word from the upstream switch stage
//   data_valid : one-cycle strobe, capture data_in this edge
//   ovf_clr    : synchronous clear of the sticky overflow flag
//   ser_out    : serial line, idle high, registered
//   busy       : high from the edge entering START to the edge leaving STOP
//   fifo_full  : FIFO holds DEPTH words
//   fifo_cnt   : words currently buffered
//   overflow   : sticky, a strobe arrived while the FIFO was full
// -----------------------------------------------------------------------------
module data_tx_ser
   import data_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      data_valid,
   input  logic                      ovf_clr,
   output logic                      ser_out,
   output logic                      busy,
   output logic                      fifo_full,
   output logic [cnt_w(DEPTH)-1:0]   fifo_cnt,
   output logic                      overflow
);

   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_W);

   tx_state_e         state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              ser_q, ser_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;

   logic              fifo_pop;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              bit_end;
   logic              load;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .res   (res),
      .push  (data_valid),
      .pop   (fifo_pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .cnt   (fifo_cnt)
   );

   assign bit_end = (tmr_q == TMR_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      par_d    = par_q;
      fifo_pop = 1'b0;
      load     = 1'b0;
      tmr_d    = (state_q == IDLE || bit_end) ? '0 : tmr_q + TMR_W'(1);

      case (state_q)
         IDLE: begin
            load = !fifo_empty;
         end
         START: begin
            idx_d = '0;
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == IDX_W'(DATA_W - 1)) begin
                  state_d = PARITY;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            // A queued word chains straight into the next START so
            // back-to-back frames leave no idle gap on the line.
            if (bit_end) begin
               state_d = IDLE;
               load    = !fifo_empty;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_dout;
         par_d    = ^fifo_dout;
         state_d  = START;
      end
   end

   // The line level reflects the state held during the cycle just ending,
   // so ser_out trails the state register by one clock.
   always_comb begin
      ser_d = IDLE_LVL;
      case (state_q)
         IDLE:    ser_d = IDLE_LVL;
         START:   ser_d = START_BIT;
         DATA:    ser_d = shift_q[0];
         PARITY:  ser_d = par_q;
         STOP:    ser_d = STOP_BIT;
         default: ser_d = IDLE_LVL;
      endcase
   end

   assign busy_d = (state_d != IDLE);

   // Set wins over clear; fullness is the pre-edge value.
   assign ovf_d = (data_valid && fifo_full) ? 1'b1 :
                  (ovf_clr ? 1'b0 : ovf_q);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         idx_q   <= '0;
         ser_q   <= IDLE_LVL;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         ser_q   <= ser_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   // Frame payload registers carry data only.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   assign ser_out  = ser_q;
   assign busy     = busy_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_data_tx_ser.sv
module tb_data_tx_ser;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int CPB    = 4;
   localparam int FRAME  = (DATA_W + 3) * CPB;

   logic              clk = 1'b0;
   logic              res;
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              ovf_clr;
   logic              ser_out;
   logic              busy;
   logic              fifo_full;
   logic [2:0]        fifo_cnt;
   logic              overflow;

   int n_tests = 0;
   int n_fail  = 0;

   data_tx_ser #(
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .res        (res),
      .data_in    (data_in),
      .data_valid (data_valid),
      .ovf_clr    (ovf_clr),
      .ser_out    (ser_out),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .fifo_cnt   (fifo_cnt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected line level of frame bit b: 0 start, 1..8 data LSB first,
   // 9 even parity, 10 stop.
   function automatic logic exp_lvl(input logic [7:0] w, input int b);
      if (b == 0)       return 1'b0;
      else if (b <= 8)  return w[b-1];
      else if (b == 9)  return ^w;
      else              return 1'b1;
   endfunction

   // Called just after the edge that entered START; checks every cycle of
   // the frame from cycle index 'first' and counts busy samples.
   task automatic frame_chk(input logic [7:0] w, input int first, output int busy_n);
      busy_n = 0;
      for (int j = first; j < FRAME; j++) begin
         step();
         chk($sformatf("ser_%02h_c%0d", w, j), ser_out, exp_lvl(w, j / CPB));
         if (busy) busy_n++;
      end
   endtask

   int bn;
   int bsum;
   logic noisy;

   initial begin
      res        = 1'b1;
      data_in    = '0;
      data_valid = 1'b0;
      ovf_clr    = 1'b0;
      step();
      step();
      chk("rst_ser",  ser_out,   1'b1);
      chk("rst_busy", busy,      1'b0);
      chk("rst_cnt",  fifo_cnt,  3'd0);
      chk("rst_full", fifo_full, 1'b0);
      chk("rst_ovf",  overflow,  1'b0);
      res = 1'b0;
      step();

      // ---- single word 0xA5 ----
      data_in = 8'hA5; data_valid = 1'b1;
      step();                               // edge k
      data_valid = 1'b0;
      chk("a5_cnt_k",  fifo_cnt, 3'd1);
      chk("a5_busy_k", busy,     1'b0);
      step();                               // edge k+1: pop, START
      chk("a5_cnt_k1",  fifo_cnt, 3'd0);
      chk("a5_busy_k1", busy,     1'b1);
      chk("a5_ser_k1",  ser_out,  1'b1);
      frame_chk(8'hA5, 0, bn);
      chk("a5_busy_len", bn + 1, 44);
      chk("a5_busy_end", busy,   1'b0);
      chk("a5_cnt_end",  fifo_cnt, 3'd0);

      // ---- back-to-back 0x07 then 0x80, odd-weight parity ----
      step();
      data_in = 8'h07; data_valid = 1'b1;
      step();                               // edge k
      data_in = 8'h80;
      step();                               // edge k+1: pop 07, push 80
      data_valid = 1'b0;
      chk("b2b_cnt", fifo_cnt, 3'd1);
      frame_chk(8'h07, 0, bn);
      chk("b2b_nogap_busy", busy, 1'b1);
      chk("b2b_cnt_pop",    fifo_cnt, 3'd0);
      frame_chk(8'h80, 0, bn);
      chk("b2b_busy_end", busy, 1'b0);

      // ---- overflow: six strobes 0x01..0x06 ----
      step();
      for (int i = 0; i < 6; i++) begin
         data_in = 8'(i + 1); data_valid = 1'b1;
         step();                            // edge k+i
         if (i >= 2) chk($sformatf("ovf_start_%0d", i), ser_out, 1'b0);
         chk($sformatf("ovf_cnt_%0d", i),  fifo_cnt,  (i == 0) ? 1 : (i >= 4 ? 4 : i));
         chk($sformatf("ovf_full_%0d", i), fifo_full, (i >= 4) ? 1 : 0);
         chk($sformatf("ovf_flag_%0d", i), overflow,  (i == 5) ? 1 : 0);
      end
      data_valid = 1'b0;
      frame_chk(8'h01, 4, bn);
      for (int i = 2; i <= 5; i++) frame_chk(8'(i), 0, bn);
      chk("ovf_busy_end", busy,     1'b0);
      chk("ovf_cnt_end",  fifo_cnt, 3'd0);
      chk("ovf_sticky",   overflow, 1'b1);

      // ---- overflow clear ----
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("clr_ovf", overflow, 1'b0);

      // ---- clear vs dropped strobe, then full + pop on same edge ----
      for (int i = 0; i < 6; i++) begin
         data_in = 8'h11 + 8'(i); data_valid = 1'b1;
         ovf_clr = (i == 5);
         step();                            // edge k+i
      end
      data_valid = 1'b0; ovf_clr = 1'b0;
      chk("setwin_ovf", overflow, 1'b1);
      chk("setwin_cnt", fifo_cnt, 3'd4);
      ovf_clr = 1'b1;
      step();                               // edge k+6
      ovf_clr = 1'b0;
      chk("clr2_ovf", overflow, 1'b0);
      for (int i = 0; i < 38; i++) step();  // now after edge k+44
      chk("fp_pre_cnt",  fifo_cnt,  3'd4);
      chk("fp_pre_full", fifo_full, 1'b1);
      data_in = 8'h99; data_valid = 1'b1;
      step();                               // edge k+45: STOP->next, pop
      data_valid = 1'b0;
      chk("fp_ovf",  overflow,  1'b1);
      chk("fp_cnt",  fifo_cnt,  3'd3);
      chk("fp_full", fifo_full, 1'b0);
      chk("fp_busy", busy,      1'b1);
      frame_chk(8'h12, 0, bn);

      // ---- reset mid-frame ----
      #2 res = 1'b1;
      #1;
      res = 1'b0;
      step();
      data_in = 8'h3C; data_valid = 1'b1;
      step();                               // edge k
      data_in = 8'h01;
      step();                               // edge k+1
      data_in = 8'h02;
      step();                               // edge k+2
      data_valid = 1'b0;
      chk("mr_cnt_q", fifo_cnt, 3'd2);
      for (int i = 0; i < 8; i++) step();   // after edge k+10, DATA bit 1
      chk("mr_busy_mid", busy,    1'b1);
      chk("mr_ser_mid",  ser_out, 1'b0);
      #2 res = 1'b1;
      #1;
      chk("mr_ser",  ser_out,   1'b1);
      chk("mr_busy", busy,      1'b0);
      chk("mr_cnt",  fifo_cnt,  3'd0);
      chk("mr_full", fifo_full, 1'b0);
      step();
      res = 1'b0;
      noisy = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (ser_out !== 1'b1 || busy !== 1'b0 || fifo_cnt !== 3'd0) noisy = 1'b1;
      end
      chk("mr_quiet", noisy, 1'b0);

      // ---- recovery after reset ----
      data_in = 8'h5A; data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      step();
      chk("rec_busy", busy, 1'b1);
      frame_chk(8'h5A, 0, bn);
      chk("rec_busy_end", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end

endmodule
